// File: rtl/qubit_state_discriminator_pkg.sv
// Shared widths and the discriminator state encoding used by the readout
// integrator, the discriminator and the host interface.
package qubit_pkg;

    localparam int IQ_W   = 35;
    localparam int COEF_W = 16;
    localparam int SHOT_W = 16;
    localparam int PROD_W = IQ_W + COEF_W;
    localparam int PROJ_W = IQ_W + COEF_W + 1;

    localparam logic [SHOT_W-1:0] SHOT_ONE  = 16'd1;
    localparam logic [SHOT_W-1:0] SHOT_ZERO = 16'd0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } disc_state_t;

endpackage

// File: rtl/qubit_state_discriminator_iq_projector.sv
// Two-stage projection pipeline: stage 1 registers both axis products,
// stage 2 registers the full-precision sum compared against the threshold.
module iq_projector
    import qubit_pkg::*;
(
    input  logic                     clk100,
    input  logic                     reset,
    input  logic                     in_valid,
    input  logic signed [IQ_W-1:0]   i_val,
    input  logic signed [IQ_W-1:0]   q_val,
    input  logic signed [COEF_W-1:0] coef_i,
    input  logic signed [COEF_W-1:0] coef_q,
    input  logic signed [PROJ_W-1:0] threshold,
    output logic                     nxt_valid,
    output logic                     nxt_bit,
    output logic                     out_valid,
    output logic                     out_bit
);

    logic signed [PROD_W-1:0] coef_i_ext_s;
    logic signed [PROD_W-1:0] coef_q_ext_s;
    logic signed [PROD_W-1:0] i_ext_s;
    logic signed [PROD_W-1:0] q_ext_s;
    logic signed [PROD_W-1:0] prod_i_r;
    logic signed [PROD_W-1:0] prod_q_r;
    logic                     valid_s1_r;
    logic signed [PROJ_W-1:0] proj_s;

    // Operands are sign-extended to the product width so the multiply is exact.
    assign coef_i_ext_s = $signed({{IQ_W{coef_i[COEF_W-1]}}, coef_i});
    assign coef_q_ext_s = $signed({{IQ_W{coef_q[COEF_W-1]}}, coef_q});
    assign i_ext_s      = $signed({{COEF_W{i_val[IQ_W-1]}}, i_val});
    assign q_ext_s      = $signed({{COEF_W{q_val[IQ_W-1]}}, q_val});

    // The extra sum bit keeps the addition from overflowing.
    assign proj_s    = $signed({prod_i_r[PROD_W-1], prod_i_r} + {prod_q_r[PROD_W-1], prod_q_r});
    assign nxt_valid = valid_s1_r;
    assign nxt_bit   = valid_s1_r && (proj_s > threshold);

    // Stage 1: product registers.
    always_ff @(posedge clk100 or posedge reset) begin
        if (reset) begin
            valid_s1_r <= 1'b0;
            prod_i_r   <= '0;
            prod_q_r   <= '0;
        end else begin
            valid_s1_r <= in_valid;
            prod_i_r   <= coef_i_ext_s * i_ext_s;
            prod_q_r   <= coef_q_ext_s * q_ext_s;
        end
    end

    // Stage 2: decision register.
    always_ff @(posedge clk100 or posedge reset) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_bit   <= 1'b0;
        end else begin
            out_valid <= nxt_valid;
            out_bit   <= nxt_bit;
        end
    end

endmodule

// File: rtl/qubit_state_discriminator.sv
// Run controller for shot discrimination: arms a run, admits up to num_shots
// strobes into the projector, counts outcomes and holds them until acked.
module qubit_state_discriminator
    import qubit_pkg::*;
(
    input  logic                     clk100,
    input  logic                     reset,
    input  logic                     arm,
    input  logic [SHOT_W-1:0]        num_shots,
    input  logic signed [COEF_W-1:0] coef_i,
    input  logic signed [COEF_W-1:0] coef_q,
    input  logic signed [PROJ_W-1:0] threshold,
    input  logic                     iq_valid,
    input  logic signed [IQ_W-1:0]   i_val_tot,
    input  logic signed [IQ_W-1:0]   q_val_tot,
    input  logic                     result_ack,
    output logic                     busy,
    output logic                     state_valid,
    output logic                     state_bit,
    output logic                     done,
    output logic [SHOT_W-1:0]        shot_count,
    output logic [SHOT_W-1:0]        excited_count
);

    disc_state_t              state_r;
    disc_state_t              state_nxt_s;
    logic [SHOT_W-1:0]        num_shots_r;
    logic signed [COEF_W-1:0] coef_i_r;
    logic signed [COEF_W-1:0] coef_q_r;
    logic signed [PROJ_W-1:0] threshold_r;
    logic [SHOT_W-1:0]        issued_r;
    logic                     arm_s;
    logic                     accept_s;
    logic                     nxt_valid_s;
    logic                     nxt_bit_s;

    assign arm_s    = (state_r == IDLE) && arm && (num_shots != SHOT_ZERO);
    assign accept_s = (state_r == RUN) && iq_valid && (issued_r < num_shots_r);

    iq_projector u_proj (
        .clk100    (clk100),
        .reset     (reset),
        .in_valid  (accept_s),
        .i_val     (i_val_tot),
        .q_val     (q_val_tot),
        .coef_i    (coef_i_r),
        .coef_q    (coef_q_r),
        .threshold (threshold_r),
        .nxt_valid (nxt_valid_s),
        .nxt_bit   (nxt_bit_s),
        .out_valid (state_valid),
        .out_bit   (state_bit)
    );

    // Next-state logic; the run ends one cycle after its last result appears.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (arm_s) state_nxt_s = RUN;
                else       state_nxt_s = IDLE;
            end
            RUN: begin
                if (state_valid && (shot_count == num_shots_r)) state_nxt_s = HOLD;
                else                                             state_nxt_s = RUN;
            end
            HOLD: begin
                if (result_ack) state_nxt_s = IDLE;
                else            state_nxt_s = HOLD;
            end
            default: state_nxt_s = IDLE;
        endcase
    end

    // State register with registered status flags.
    always_ff @(posedge clk100 or posedge reset) begin
        if (reset) begin
            state_r <= IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            busy    <= (state_nxt_s == RUN);
            done    <= (state_nxt_s == HOLD);
        end
    end

    // Run configuration, admission counter and result counters.
    always_ff @(posedge clk100 or posedge reset) begin
        if (reset) begin
            num_shots_r   <= '0;
            coef_i_r      <= '0;
            coef_q_r      <= '0;
            threshold_r   <= '0;
            issued_r      <= '0;
            shot_count    <= '0;
            excited_count <= '0;
        end else if (arm_s) begin
            num_shots_r   <= num_shots;
            coef_i_r      <= coef_i;
            coef_q_r      <= coef_q;
            threshold_r   <= threshold;
            issued_r      <= '0;
            shot_count    <= '0;
            excited_count <= '0;
        end else begin
            if (accept_s) issued_r <= issued_r + SHOT_ONE;
            // Counted on the edge that raises state_valid so counts track it.
            if (nxt_valid_s && (state_r == RUN)) begin
                shot_count <= shot_count + SHOT_ONE;
                if (nxt_bit_s) excited_count <= excited_count + SHOT_ONE;
            end
        end
    end

endmodule
